// File: rtl/axi_rd_arbiter_if.sv
// AXI read-address / read-data channel bundle shared by the fetch and load paths.
// master: arbiter side (drives AR, rready). slave: fabric side (drives arready, R).
//   arid/araddr/arsize/arvalid  AR channel, master -> slave
//   arready                     AR ready, slave -> master
//   rid/rdata/rvalid            R channel, slave -> master
//   rready                      R ready, master -> slave
interface axi_rd_arbiter_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  modport master (output arid, araddr, arsize, arvalid, rready,
                  input  arready, rid, rdata, rvalid);
  modport slave  (input  arid, araddr, arsize, arvalid, rready,
                  output arready, rid, rdata, rvalid);
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI AR/R channel pair between instruction fetch
// (id 0) and loads (id 1), each using a req/addr_ok/data_ok handshake.
// Tracks outstanding reads per requester, routes R beats by rid[0], holds
// back loads that hit the word of a pending store, and drops fetch data that
// was outstanding when inst_cancel_i pulsed.
// Ports:
//   aclk, reset                 clock, synchronous active-high reset
//   inst_*_i / inst_*_o         fetch request side
//   data_*_i / data_*_o         load request side
//   wr_pending_i, wr_addr_i     store in flight (for the read-after-write block)
//   axi                         AXI AR/R channels (master modport)
// Build option: define ARB_ROUND_ROBIN_EN to alternate between requesters when
// both are eligible; otherwise loads have fixed priority over fetches.
module axi_rd_arbiter #(
  parameter int OUTS_MAX = 2,
  parameter int CNT_W    = 2
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  input  logic [1:0]  inst_size_i,
  input  logic        inst_cancel_i,
  output logic        inst_addr_ok_o,
  output logic        inst_data_ok_o,
  output logic [31:0] inst_rdata_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic [1:0]  data_size_i,
  output logic        data_addr_ok_o,
  output logic        data_data_ok_o,
  output logic [31:0] data_rdata_o,
  input  logic        wr_pending_i,
  input  logic [31:0] wr_addr_i,
  axi_rd_arbiter_if.master axi
);

  typedef enum logic {S_IDLE, S_AR} state_e;

  state_e             state_q, state_d;
  logic [3:0]         arid_q, arid_d;
  logic [31:0]        araddr_q, araddr_d;
  logic [2:0]         arsize_q, arsize_d;
  logic [CNT_W-1:0]   inst_cnt_q, inst_cnt_d;
  logic [CNT_W-1:0]   data_cnt_q, data_cnt_d;
  logic [CNT_W-1:0]   inst_disc_q, inst_disc_d;

  logic inst_elig, data_elig, raw_hit;
  logic grant_inst, grant_data;
  logic r_inst, r_data;

  assign raw_hit   = wr_pending_i & (wr_addr_i[31:2] == data_addr_i[31:2]);
  assign inst_elig = inst_req_i & (inst_cnt_q < CNT_W'(OUTS_MAX));
  assign data_elig = data_req_i & (data_cnt_q < CNT_W'(OUTS_MAX)) & ~raw_hit;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant_q: 0 = fetch won last, 1 = load won last
  logic last_grant_q;
  logic both_elig;
  assign both_elig  = inst_elig & data_elig;
  assign grant_data = ~reset & (state_q == S_IDLE) & data_elig & (~both_elig | ~last_grant_q);
  assign grant_inst = ~reset & (state_q == S_IDLE) & inst_elig & (~both_elig |  last_grant_q);

  always_ff @(posedge aclk) begin
    if (reset)                        last_grant_q <= 1'b0;
    else if (grant_data | grant_inst) last_grant_q <= grant_data;
  end
`else
  assign grant_data = ~reset & (state_q == S_IDLE) & data_elig;
  assign grant_inst = ~reset & (state_q == S_IDLE) & inst_elig & ~data_elig;
`endif

  // R routing: every beat is accepted; rid[0] selects the requester
  assign r_inst = ~reset & axi.rvalid & ~axi.rid[0];
  assign r_data = ~reset & axi.rvalid &  axi.rid[0];

  assign inst_addr_ok_o = grant_inst;
  assign data_addr_ok_o = grant_data;
  assign inst_data_ok_o = r_inst & (inst_disc_q == '0);
  assign data_data_ok_o = r_data;
  assign inst_rdata_o   = axi.rdata;
  assign data_rdata_o   = axi.rdata;

  assign axi.arvalid = (state_q == S_AR);
  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arsize  = arsize_q;
  assign axi.rready  = 1'b1;

  always_comb begin
    state_d  = state_q;
    arid_d   = arid_q;
    araddr_d = araddr_q;
    arsize_d = arsize_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          state_d  = S_AR;
          arid_d   = 4'd1;
          araddr_d = data_addr_i;
          arsize_d = {1'b0, data_size_i};
        end else if (grant_inst) begin
          state_d  = S_AR;
          arid_d   = 4'd0;
          araddr_d = inst_addr_i;
          arsize_d = {1'b0, inst_size_i};
        end
      end
      S_AR: if (axi.arready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outstanding counters; grant and beat in the same cycle cancel out
  always_comb begin
    inst_cnt_d = inst_cnt_q;
    data_cnt_d = data_cnt_q;
    if (grant_inst & ~r_inst)      inst_cnt_d = inst_cnt_q + CNT_W'(1);
    else if (~grant_inst & r_inst) inst_cnt_d = inst_cnt_q - CNT_W'(1);
    if (grant_data & ~r_data)      data_cnt_d = data_cnt_q + CNT_W'(1);
    else if (~grant_data & r_data) data_cnt_d = data_cnt_q - CNT_W'(1);
  end

  // Discard count: everything still in flight at the cancel, including a
  // fetch granted in the cancel cycle, excluding a beat returning then.
  always_comb begin
    inst_disc_d = inst_disc_q;
    if (inst_cancel_i & ~reset)
      inst_disc_d = inst_cnt_q - CNT_W'(r_inst) + CNT_W'(grant_inst);
    else if (r_inst & (inst_disc_q != '0))
      inst_disc_d = inst_disc_q - CNT_W'(1);
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      arid_q      <= '0;
      araddr_q    <= '0;
      arsize_q    <= '0;
      inst_cnt_q  <= '0;
      data_cnt_q  <= '0;
      inst_disc_q <= '0;
    end else begin
      state_q     <= state_d;
      arid_q      <= arid_d;
      araddr_q    <= araddr_d;
      arsize_q    <= arsize_d;
      inst_cnt_q  <= inst_cnt_d;
      data_cnt_q  <= data_cnt_d;
      inst_disc_q <= inst_disc_d;
    end
  end

  // Byte offsets are irrelevant to the word-granular hazard check; upper rid bits unused
  logic unused_bits;
  assign unused_bits = ^{axi.rid[3:1], data_addr_i[1:0], wr_addr_i[1:0]};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
  logic        aclk = 1'b0;
  logic        reset;
  logic        inst_req, inst_cancel, data_req, wr_pending;
  logic [31:0] inst_addr, data_addr, wr_addr;
  logic [1:0]  inst_size, data_size;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;

  axi_rd_arbiter_if axi ();

  axi_rd_arbiter #(.OUTS_MAX(2), .CNT_W(2)) dut (
    .aclk(aclk), .reset(reset),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_size_i(inst_size),
    .inst_cancel_i(inst_cancel), .inst_addr_ok_o(inst_addr_ok),
    .inst_data_ok_o(inst_data_ok), .inst_rdata_o(inst_rdata),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_size_i(data_size),
    .data_addr_ok_o(data_addr_ok), .data_data_ok_o(data_data_ok),
    .data_rdata_o(data_rdata),
    .wr_pending_i(wr_pending), .wr_addr_i(wr_addr),
    .axi(axi.master)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic rst; logic ireq; logic [31:0] iaddr; logic dreq; logic [31:0] daddr;
    logic wp; logic [31:0] waddr; logic cancel; logic arrdy; logic rv;
    logic [3:0] rid; logic [31:0] rdata;
    logic e_iaok; logic e_daok; logic e_idok; logic e_ddok; logic e_arv;
    logic [3:0] e_arid; logic [31:0] e_araddr;
  } vec_t;

  localparam logic [31:0] W = 32'h1C000104;
  localparam logic [31:0] D = 32'h1C000106;
  vec_t v[41];

  // Inputs are driven just after the rising edge; outputs checked at the falling edge.
  task automatic apply(input vec_t t);
    @(posedge aclk); #1;
    reset = t.rst; inst_req = t.ireq; inst_addr = t.iaddr;
    data_req = t.dreq; data_addr = t.daddr; wr_pending = t.wp; wr_addr = t.waddr;
    inst_cancel = t.cancel; axi.arready = t.arrdy; axi.rvalid = t.rv;
    axi.rid = t.rid; axi.rdata = t.rdata;
  endtask

  initial begin
    reset = 1'b1; inst_req = 0; inst_addr = 0; inst_size = 2'd2; inst_cancel = 0;
    data_req = 0; data_addr = 0; data_size = 2'd1; wr_pending = 0; wr_addr = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rid = 0; axi.rdata = 0;

    // rst ireq iaddr dreq daddr wp waddr cancel arrdy rv rid rdata | iaok daok idok ddok arv arid araddr
    v[0]  = '{0,1,32'h1000,1,32'h2000,0,0,0,1,0,0,0,          0,1,0,0,0,0,32'h0};
    v[1]  = '{0,1,32'h1000,0,0,0,0,0,1,0,0,0,                 0,0,0,0,1,1,32'h2000};
    v[2]  = '{0,1,32'h1000,0,0,0,0,0,1,0,0,0,                 1,0,0,0,0,1,32'h2000};
    v[3]  = '{0,1,32'h1004,0,0,0,0,0,1,0,0,0,                 0,0,0,0,1,0,32'h1000};
    v[4]  = '{0,1,32'h1004,0,0,0,0,0,0,0,0,0,                 1,0,0,0,0,0,32'h1000};
    v[5]  = '{0,1,32'h1008,0,0,0,0,0,1,0,0,0,                 0,0,0,0,1,0,32'h1004};
    v[6]  = '{0,1,32'h1008,0,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,32'h1004};
    v[7]  = '{0,1,32'h1008,0,0,0,0,0,0,1,1,32'h55,            0,0,0,1,0,0,32'h1004};
    v[8]  = '{0,1,32'h1008,0,0,0,0,0,0,1,0,32'hAAAA,          0,0,1,0,0,0,32'h1004};
    v[9]  = '{0,1,32'h1008,0,0,0,0,0,0,0,0,0,                 1,0,0,0,0,0,32'h1004};
    v[10] = '{0,0,0,0,0,0,0,0,1,0,0,0,                        0,0,0,0,1,0,32'h1008};
    v[11] = '{0,0,0,0,0,0,0,1,0,0,0,0,                        0,0,0,0,0,0,32'h1008};
    v[12] = '{0,0,0,0,0,0,0,0,0,1,0,32'h1111,                 0,0,0,0,0,0,32'h1008};
    v[13] = '{0,0,0,0,0,0,0,0,0,1,0,32'h2222,                 0,0,0,0,0,0,32'h1008};
    v[14] = '{0,1,32'h100C,0,0,0,0,0,0,0,0,0,                 1,0,0,0,0,0,32'h1008};
    v[15] = '{0,0,0,0,0,0,0,0,1,0,0,0,                        0,0,0,0,1,0,32'h100C};
    v[16] = '{0,0,0,0,0,0,0,0,0,1,0,32'h3333,                 0,0,1,0,0,0,32'h100C};
    v[17] = '{0,1,32'h1010,1,D,1,W,0,0,0,0,0,                 1,0,0,0,0,0,32'h100C};
    v[18] = '{0,0,0,1,D,1,W,0,1,0,0,0,                        0,0,0,0,1,0,32'h1010};
    v[19] = '{0,0,0,1,D,1,W,0,0,0,0,0,                        0,0,0,0,0,0,32'h1010};
    v[20] = '{0,0,0,1,D,0,W,0,0,0,0,0,                        0,1,0,0,0,0,32'h1010};
    v[21] = '{0,0,0,0,0,0,0,0,0,0,0,0,                        0,0,0,0,1,1,D};
    for (int i = 22; i < 26; i++)
      v[i] = '{0,1,32'h3000,1,32'h3004,0,0,0,0,0,0,0,         0,0,0,0,1,1,D};
    v[26] = '{1,1,32'h3000,1,32'h3004,0,0,0,0,0,0,0,          0,0,0,0,1,1,D};
    v[27] = '{0,0,0,0,0,0,0,0,0,0,0,0,                        0,0,0,0,0,0,32'h0};
    v[28] = '{0,1,32'h2000,0,0,0,0,0,0,0,0,0,                 1,0,0,0,0,0,32'h0};
    v[29] = '{0,0,0,0,0,0,0,0,1,0,0,0,                        0,0,0,0,1,0,32'h2000};
    v[30] = '{0,1,32'h2004,0,0,0,0,0,0,0,0,0,                 1,0,0,0,0,0,32'h2000};
    v[31] = '{0,0,0,0,0,0,0,0,1,0,0,0,                        0,0,0,0,1,0,32'h2004};
    v[32] = '{0,1,32'h2008,0,0,0,0,0,0,0,0,0,                 0,0,0,0,0,0,32'h2004};
    v[33] = '{0,0,0,0,0,0,0,1,0,1,0,32'h4444,                 0,0,1,0,0,0,32'h2004};
    v[34] = '{0,0,0,0,0,0,0,0,0,1,0,32'h5555,                 0,0,0,0,0,0,32'h2004};
    v[35] = '{0,1,32'h200C,0,0,0,0,1,0,0,0,0,                 1,0,0,0,0,0,32'h2004};
    v[36] = '{0,0,0,0,0,0,0,0,1,0,0,0,                        0,0,0,0,1,0,32'h200C};
    v[37] = '{0,0,0,0,0,0,0,0,0,1,0,32'h6666,                 0,0,0,0,0,0,32'h200C};
    v[38] = '{0,1,32'h2010,0,0,0,0,0,0,0,0,0,                 1,0,0,0,0,0,32'h200C};
    v[39] = '{0,0,0,0,0,0,0,0,1,0,0,0,                        0,0,0,0,1,0,32'h2010};
    v[40] = '{0,0,0,0,0,0,0,0,0,1,0,32'h7777,                 0,0,1,0,0,0,32'h2010};

    // Reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_arvalid", {31'b0, axi.arvalid}, 0);
    chk("rst_arid", {28'b0, axi.arid}, 0);
    chk("rst_araddr", axi.araddr, 0);
    chk("rst_arsize", {29'b0, axi.arsize}, 0);
    chk("rst_rready", {31'b0, axi.rready}, 1);

    foreach (v[i]) begin
      apply(v[i]);
      @(negedge aclk);
      chk($sformatf("v%0d_iaok", i), {31'b0, inst_addr_ok}, {31'b0, v[i].e_iaok});
      chk($sformatf("v%0d_daok", i), {31'b0, data_addr_ok}, {31'b0, v[i].e_daok});
      chk($sformatf("v%0d_idok", i), {31'b0, inst_data_ok}, {31'b0, v[i].e_idok});
      chk($sformatf("v%0d_ddok", i), {31'b0, data_data_ok}, {31'b0, v[i].e_ddok});
      chk($sformatf("v%0d_arvalid", i), {31'b0, axi.arvalid}, {31'b0, v[i].e_arv});
      chk($sformatf("v%0d_arid", i), {28'b0, axi.arid}, {28'b0, v[i].e_arid});
      chk($sformatf("v%0d_araddr", i), axi.araddr, v[i].e_araddr);
      if (v[i].e_arv)
        chk($sformatf("v%0d_arsize", i), {29'b0, axi.arsize}, v[i].e_arid[0] ? 32'd1 : 32'd2);
      if (v[i].e_idok) chk($sformatf("v%0d_irdata", i), inst_rdata, v[i].rdata);
      if (v[i].e_ddok) chk($sformatf("v%0d_drdata", i), data_rdata, v[i].rdata);
    end

    // Both requesters continuously eligible: grant order by build option.
    begin
      vec_t t;
      logic exp_d;
      t = '{1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0};
      apply(t);
      for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = (k % 2 == 0);
`else
        exp_d = 1'b1;
`endif
        t = '{0,1,32'h4000,1,32'h5000,0,0,0,0,0,0,0, 0,0,0,0,0,0,0};
        apply(t);
        @(negedge aclk);
        chk($sformatf("rr%0d_daok", k), {31'b0, data_addr_ok}, {31'b0, exp_d});
        chk($sformatf("rr%0d_iaok", k), {31'b0, inst_addr_ok}, {31'b0, ~exp_d});
        // AR handshake plus the matching R beat in the next cycle keeps counters low
        t = '{0,1,32'h4000,1,32'h5000,0,0,0,1,1,{3'b0, exp_d},32'h0, 0,0,0,0,0,0,0};
        apply(t);
        @(negedge aclk);
        chk($sformatf("rr%0d_arid", k), {28'b0, axi.arid}, {31'b0, exp_d});
        chk($sformatf("rr%0d_araddr", k), axi.araddr, exp_d ? 32'h5000 : 32'h4000);
        chk($sformatf("rr%0d_held", k), {31'b0, data_addr_ok | inst_addr_ok}, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
